// File: rtl/apb_master_pkg.sv
// Shared types and default sizes for the APB requester slice.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

  localparam int APB_ADDR_W      = 32;
  localparam int APB_DATA_W      = 32;
  localparam int APB_TIMEOUT_CYC = 16;

endpackage

// File: rtl/apb_master_if.sv
// Command/response handshake plus APB bus signals seen by the requester.
interface apb_master_if
  import apb_pkg::*;
#(
  parameter int ADDR_W = APB_ADDR_W,
  parameter int DATA_W = APB_DATA_W
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready, pslverr,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    output psel, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready, pslverr,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    input  psel, penable, pwrite, paddr, pwdata
  );
endinterface

// File: rtl/apb_master_wait_timer.sv
// ACCESS-phase wait counter; o_expired fires on the LIMIT-th consecutive wait cycle.
module apb_wait_timer #(
  parameter int LIMIT = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_expired
);
  localparam int CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= r_count + 1'b1;
    end
  end

  // The cycle being counted is itself the LIMIT-th one when the count is LIMIT-1.
  assign o_expired = i_inc && (r_count == CNT_W'(LIMIT - 1));
endmodule

// File: rtl/apb_master.sv
// APB requester: one command -> SETUP/ACCESS transfer -> one-cycle response pulse.
// Optional ACCESS wait limit enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_W      = APB_ADDR_W,
  parameter int DATA_W      = APB_DATA_W,
  parameter int TIMEOUT_CYC = APB_TIMEOUT_CYC
) (
  input  logic         pclk,
  input  logic         preset,
  apb_master_if.master bus
);
  apb_state_t        r_state;
  logic              r_psel;
  logic              r_penable;
  logic              r_pwrite;
  logic [ADDR_W-1:0] r_paddr;
  logic [DATA_W-1:0] r_pwdata;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_err;
  logic              w_timeout;

`ifdef APB_MASTER_TIMEOUT_EN
  apb_wait_timer #(
    .LIMIT (TIMEOUT_CYC)
  ) u_wait_timer (
    .i_clk     (pclk),
    .i_rst     (preset),
    .i_clr     (r_state == SETUP),
    .i_inc     ((r_state == ACCESS) && !bus.pready),
    .o_expired (w_timeout)
  );
`else
  // Constant 0: without the wait limit ACCESS only ends on pready.
  assign w_timeout = (TIMEOUT_CYC < 0);
`endif

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      r_state     <= IDLE;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.cmd_valid) begin
            r_pwrite  <= bus.cmd_write;
            r_paddr   <= bus.cmd_addr;
            r_pwdata  <= bus.cmd_wdata;
            r_psel    <= 1'b1;
            r_penable <= 1'b0;
            r_state   <= SETUP;
          end
        end
        SETUP: begin
          r_penable <= 1'b1;
          r_state   <= ACCESS;
        end
        ACCESS: begin
          // pready takes priority over a limit reached in the same cycle.
          if (bus.pready) begin
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_state     <= IDLE;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= bus.pslverr;
            r_rsp_rdata <= (!r_pwrite && !bus.pslverr) ? bus.prdata : '0;
          end else if (w_timeout) begin
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_state     <= IDLE;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
            r_rsp_rdata <= '0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = (r_state == IDLE) && !preset;
  assign bus.psel      = r_psel;
  assign bus.penable   = r_penable;
  assign bus.pwrite    = r_pwrite;
  assign bus.paddr     = r_paddr;
  assign bus.pwdata    = r_pwdata;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_err   = r_rsp_err;
endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
- APB requester (initiator) that converts a simple valid/ready command interface into APB SETUP/ACCESS transfers toward APB completers such as the 32-entry register/memory slave.
- Each transfer returns a one-cycle response pulse carrying read data and error status.
- Sits between a local controller or bench driver and the APB bus. One outstanding transfer at a time.

Parameters:
- ADDR_W, 32, width of cmd_addr/paddr
- DATA_W, 32, width of write/read data
- TIMEOUT_CYC, 16, ACCESS-phase wait limit in cycles (used only with the optional feature)

Ports:
- pclk  in  1  APB clock, all logic on rising edge
- preset  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  transfer address
- cmd_wdata  in  DATA_W  write data
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  DATA_W  read data (0 for writes and errors)
- rsp_err  out  1  transfer ended with pslverr (or timeout)
- psel  out  1  APB select
- penable  out  1  APB enable
- pwrite  out  1  APB direction
- paddr  out  ADDR_W  APB address
- pwdata  out  DATA_W  APB write data
- prdata  in  DATA_W  APB read data
- pready  in  1  completer ready
- pslverr  in  1  completer error, valid only with pready in ACCESS

Behaviour:
- Clock and reset: one clock, pclk; reset preset is asynchronous, active-high.
- Reset values: state=IDLE; psel, penable, pwrite, rsp_valid, rsp_err = 0; paddr, pwdata, rsp_rdata = 0. cmd_ready = 0 while preset is high.
- FSM states: IDLE, SETUP, ACCESS. All APB outputs are registered.
- cmd_ready:
  - cmd_ready = (state==IDLE) && !preset.
  - cmd_ready is combinational from state only and does not depend on cmd_valid.
- IDLE:
  - On accept, latch cmd_write/cmd_addr/cmd_wdata into pwrite/paddr/pwdata, set psel=1, penable=0, and go to SETUP.
  - pwdata is loaded for reads too; the slave ignores it.
- SETUP: lasts exactly one cycle; set penable=1 and go to ACCESS.
- ACCESS:
  - Hold psel=1, penable=1, and paddr/pwdata/pwrite stable while pready=0. Wait states are unlimited.
  - On pready=1, clear psel and penable and go to IDLE.
  - In the same edge, drive rsp_valid=1 for one cycle and rsp_err=pslverr.
  - rsp_rdata = prdata if read && !pslverr, else 0.
- Latency:
  - Accept edge, then SETUP cycle, then ACCESS cycle(s). rsp_valid is high the cycle after pready is sampled.
  - Zero-wait transfer: cmd accepted at edge N, rsp_valid high in cycle N+3.
  - Minimum command-to-command spacing is 3 cycles. Back-to-back ACCESS→SETUP is not supported.
- Output hold rules:
  - paddr, pwdata and pwrite hold their last values in IDLE; no return to 0.
  - rsp_rdata and rsp_err hold until the next response.
- pslverr or prdata with pready=0, or outside ACCESS: ignored.
- cmd_valid while not in IDLE: ignored and not queued. The requester must keep cmd_valid high until accepted.
- Reset mid-transfer:
  - Asynchronous return to IDLE with psel and penable cleared immediately.
  - No response is generated for the aborted transfer.
- Width: all data paths pass through unmodified. No byte strobes or pprot.

Optional Feature:
- Macro: APB_MASTER_TIMEOUT_EN.
- Enabled:
  - A counter clears on SETUP→ACCESS and increments each ACCESS cycle with pready=0.
  - When the count reaches TIMEOUT_CYC without pready, abort the transfer: psel and penable drop to 0, state goes to IDLE, and rsp_valid=1 with rsp_err=1 and rsp_rdata=0.
  - A pready arriving in the same cycle the limit is reached wins: normal completion.
- Disabled: no counter logic; ACCESS waits indefinitely for pready.

Decomposition:
- Shared package apb_pkg:
  - typedef apb_state_t {IDLE, SETUP, ACCESS}
  - localparams APB_ADDR_W=32, APB_DATA_W=32
  - default TIMEOUT_CYC constant
- One natural sub-module: apb_wait_timer (counter plus limit compare), instantiated only under APB_MASTER_TIMEOUT_EN.

Test Plan:
- Write 0x0000_0004 / 0xDEAD_BEEF, pready tied high → psel high 2 cycles, penable high 1 cycle, pwrite=1; rsp_valid pulse with rsp_err=0 and rsp_rdata=0.
- Read 0x0000_0004 with prdata=0xDEAD_BEEF, pready low 3 ACCESS cycles → paddr stable throughout; rsp_rdata=0xDEAD_BEEF exactly one cycle after pready.
- Read with pslverr=1 at pready → rsp_err=1, rsp_rdata=0. Next command is accepted normally.
- cmd_valid held high during ACCESS with a different address → second command is not accepted until IDLE; paddr is unchanged mid-transfer.
- preset asserted during ACCESS → psel and penable go 0 asynchronously, with no rsp_valid. After release, cmd_ready=1.
- With APB_MASTER_TIMEOUT_EN and pready held 0 → abort after exactly 16 ACCESS cycles with rsp_err=1. Without the macro, psel is still high after 100 cycles.
